// File: rtl/tictactoe_game_ctrl_pkg.sv
// Shared definitions for the tic-tac-toe turn controller:
// FSM states, player and winner codes, and the eight winning-line masks.
package tictactoe_game_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_PLAY  = 2'd0,
        ST_CHECK = 2'd1,
        ST_WIN   = 2'd2,
        ST_DRAW  = 2'd3
    } state_e;

    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    localparam logic [1:0] WINNER_NONE = 2'b00;
    localparam logic [1:0] WINNER_X    = 2'b01;
    localparam logic [1:0] WINNER_O    = 2'b10;
    localparam logic [1:0] WINNER_DRAW = 2'b11;

    // Index order is the tie-break priority: rows, columns, diagonals.
    localparam logic [8:0] WIN_LINE0 = 9'h007;
    localparam logic [8:0] WIN_LINE1 = 9'h038;
    localparam logic [8:0] WIN_LINE2 = 9'h1C0;
    localparam logic [8:0] WIN_LINE3 = 9'h049;
    localparam logic [8:0] WIN_LINE4 = 9'h092;
    localparam logic [8:0] WIN_LINE5 = 9'h124;
    localparam logic [8:0] WIN_LINE6 = 9'h111;
    localparam logic [8:0] WIN_LINE7 = 9'h054;

    localparam logic [7:0][8:0] WIN_LINES = {
        WIN_LINE7, WIN_LINE6, WIN_LINE5, WIN_LINE4,
        WIN_LINE3, WIN_LINE2, WIN_LINE1, WIN_LINE0
    };

endpackage

// File: rtl/tictactoe_win_detect.sv
// Combinational three-in-a-row detector for one player's grid.
// Reports the lowest-indexed completed line when several are complete.
module tictactoe_win_detect
    import tictactoe_game_ctrl_pkg::*;
(
    input  logic [8:0] grid,
    output logic       win,
    output logic [8:0] line
);

    always_comb begin
        win  = 1'b0;
        line = 9'h000;
        // Walk from lowest priority up so the highest priority match wins.
        for (int i = 7; i >= 0; i--) begin
            if ((grid & WIN_LINES[i]) == WIN_LINES[i]) begin
                win  = 1'b1;
                line = WIN_LINES[i];
            end
        end
    end

endmodule

// File: rtl/tictactoe_game_ctrl.sv
// Turn sequencer for the shared 3x3 board: commits moves, enforces the
// per-move timer, detects win/draw and alternates the starting player.
module tictactoe_game_ctrl
    import tictactoe_game_ctrl_pkg::*;
#(
    parameter int MOVE_TIMEOUT = 50_000_000,
    parameter int TMR_W        = 26
) (
    input  logic       CLOCK,
    input  logic       reset_in,
    input  logic [3:0] cell_cursor,
    input  logic       cell_enter,
    input  logic       new_game,
    output logic [8:0] grid_x,
    output logic [8:0] grid_o,
    output logic [8:0] grid_state_marked,
    output logic       turn,
    output logic       game_over,
    output logic [1:0] winner,
    output logic [8:0] win_line,
    output logic [3:0] move_count,
    output logic       illegal_move,
    output logic       move_timeout
);

    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MOVE_TIMEOUT - 1);
    localparam logic             TMR_ON   = (MOVE_TIMEOUT != 0);

    state_e           state_q, state_d;
    logic [8:0]       grid_x_q, grid_x_d;
    logic [8:0]       grid_o_q, grid_o_d;
    logic             turn_q, turn_d;
    logic             start_q, start_d;
    logic [3:0]       count_q, count_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [1:0]       winner_q, winner_d;
    logic [8:0]       line_q, line_d;
    logic             over_q, over_d;
    logic             illegal_q, illegal_d;
    logic             tout_q, tout_d;

    logic [8:0]  marked;
    logic [15:0] occ;
    logic [8:0]  mover_grid;
    logic [8:0]  cell_bit;
    logic        cursor_ok;
    logic        cell_free;
    logic        legal;
    logic        expire;
    logic        det_win;
    logic [8:0]  det_line;

    assign marked     = grid_x_q | grid_o_q;
    assign occ        = {7'b0, marked};
    assign cursor_ok  = (cell_cursor <= 4'd8);
    assign cell_free  = ~occ[cell_cursor];
    assign cell_bit   = 9'b1 << cell_cursor;
    assign legal      = cell_enter && cursor_ok && cell_free;
    assign expire     = TMR_ON && (timer_q == TMR_LAST);
    assign mover_grid = (turn_q == PLAYER_O) ? grid_o_q : grid_x_q;

    tictactoe_win_detect u_win_detect (
        .grid (mover_grid),
        .win  (det_win),
        .line (det_line)
    );

    always_comb begin
        state_d   = state_q;
        grid_x_d  = grid_x_q;
        grid_o_d  = grid_o_q;
        turn_d    = turn_q;
        start_d   = start_q;
        count_d   = count_q;
        timer_d   = timer_q;
        winner_d  = winner_q;
        line_d    = line_q;
        illegal_d = 1'b0;
        tout_d    = 1'b0;

        if (new_game) begin
            state_d  = ST_PLAY;
            grid_x_d = 9'h000;
            grid_o_d = 9'h000;
            count_d  = 4'd0;
            timer_d  = '0;
            winner_d = WINNER_NONE;
            line_d   = 9'h000;
            turn_d   = ~start_q;
            start_d  = ~start_q;
        end else begin
            unique case (state_q)
                ST_PLAY: begin
                    if (legal) begin
                        if (turn_q == PLAYER_O) grid_o_d = grid_o_q | cell_bit;
                        else                    grid_x_d = grid_x_q | cell_bit;
                        count_d = count_q + 4'd1;
                        timer_d = '0;
                        state_d = ST_CHECK;
                    end else begin
                        illegal_d = cell_enter;
                        if (expire) begin
                            turn_d  = ~turn_q;
                            timer_d = '0;
                            tout_d  = 1'b1;
                        end else if (TMR_ON) begin
                            timer_d = timer_q + TMR_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (det_win) begin
                        state_d  = ST_WIN;
                        winner_d = (turn_q == PLAYER_O) ? WINNER_O : WINNER_X;
                        line_d   = det_line;
                    end else if (count_q == 4'd9) begin
                        state_d  = ST_DRAW;
                        winner_d = WINNER_DRAW;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = ST_PLAY;
                    end
                end
                ST_WIN, ST_DRAW: timer_d = '0;
                default: state_d = ST_PLAY;
            endcase
        end

        over_d = (state_d == ST_WIN) || (state_d == ST_DRAW);
    end

    always_ff @(posedge CLOCK) begin
        if (reset_in) begin
            state_q   <= ST_PLAY;
            grid_x_q  <= 9'h000;
            grid_o_q  <= 9'h000;
            turn_q    <= PLAYER_X;
            start_q   <= PLAYER_X;
            count_q   <= 4'd0;
            timer_q   <= '0;
            winner_q  <= WINNER_NONE;
            line_q    <= 9'h000;
            over_q    <= 1'b0;
            illegal_q <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_x_q  <= grid_x_d;
            grid_o_q  <= grid_o_d;
            turn_q    <= turn_d;
            start_q   <= start_d;
            count_q   <= count_d;
            timer_q   <= timer_d;
            winner_q  <= winner_d;
            line_q    <= line_d;
            over_q    <= over_d;
            illegal_q <= illegal_d;
            tout_q    <= tout_d;
        end
    end

    assign grid_x            = grid_x_q;
    assign grid_o            = grid_o_q;
    assign grid_state_marked = marked;
    assign turn              = turn_q;
    assign game_over         = over_q;
    assign winner            = winner_q;
    assign win_line          = line_q;
    assign move_count        = count_q;
    assign illegal_move      = illegal_q;
    assign move_timeout      = tout_q;

endmodule
